uart_rx_framer: RTL
===================

Name: uart_rx_framer

Overview:
- UART receiver plus command-packet framer that feeds the SD-command FIFO write side.
- Deserializes 8N1 serial bytes from the host.
- Validates the packet structure: cmd byte, 4 address bytes, then 512 data bytes for cmd01 or none for cmd02.
- Emits each accepted byte as a one-cycle write strobe. A full cmd01 packet is 517 bytes, matching the FIFO depth.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- PAYLOAD_LEN, 512, data bytes following the address for cmd01.
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes inside a packet before abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx  input  1  UART serial in, idle high, asynchronous to clk.
- mosi  output  8  byte to FIFO.
- wr_en  output  1  one-cycle strobe; mosi is valid in this cycle.
- cmd  output  8  command byte of current/last packet.
- addr  output  32  address of current/last packet, big-endian assembly.
- pkt_done  output  1  one-cycle pulse coincident with wr_en of a packet's last byte.
- busy  output  1  high from cmd byte accepted until pkt_done or abort.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- cmd_err  output  1  one-cycle pulse when the first byte is not 0x01/0x02.
- timeout_err  output  1  one-cycle pulse on inter-byte timeout inside a packet.

Behaviour:
- Reset: all outputs 0, mosi=0, cmd=0, addr=0. Both FSMs go to their idle state. Reset is honoured at any time, including mid-byte or mid-packet; the partial packet is discarded and no strobe is issued.
- rx passes through a 2-flop synchronizer before any use.
- RX FSM states:
  - R_IDLE: a synchronized falling edge (0 after 1) moves to R_START and clears the bit counter.
  - R_START: at CLKS_PER_BIT/2, if rx=0 go to R_DATA. Otherwise treat it as a glitch and return to R_IDLE with no output.
  - R_DATA: sample every CLKS_PER_BIT, LSB first, 8 bits.
  - R_STOP: sample once after a further CLKS_PER_BIT.
    - rx=1: raise an internal byte_vld for one cycle (next clock), then R_IDLE.
    - rx=0: pulse frame_err, drop the byte, go to R_WAIT.
  - R_WAIT: stay until rx=1, then R_IDLE.
- Framer FSM states: F_CMD, F_ADDR, F_DATA; byte counter is 10 bits.
- F_CMD on byte_vld:
  - 0x01 or 0x02: latch cmd, clear addr, assert wr_en/mosi in the same cycle as byte_vld, set busy, go to F_ADDR.
  - Any other value: pulse cmd_err, no wr_en, stay in F_CMD.
- F_ADDR: each byte is emitted with wr_en and assembled as addr <= {addr[23:0], byte}. After the 4th byte:
  - cmd=0x02: pulse pkt_done with that wr_en, clear busy, go to F_CMD.
  - cmd=0x01: go to F_DATA.
- F_DATA: emit PAYLOAD_LEN bytes with wr_en. pkt_done accompanies the last one; then clear busy and go to F_CMD.
- Inter-byte timeout: in F_ADDR/F_DATA a counter of CLKS_PER_BIT*TIMEOUT_BITS cycles restarts on each byte_vld. On expiry: pulse timeout_err, clear busy, go to F_CMD. No further wr_en is issued.
- frame_err while busy aborts the packet the same way (busy cleared, F_CMD); timeout_err is not pulsed in that case.
- Latency: wr_en rises 2 clk after the stop-bit mid-sample (1 cycle byte_vld register, 1 cycle output register).
- Outputs are registered. cmd and addr hold their values after pkt_done until the next cmd byte is accepted.
- Back-to-back bytes with zero idle time between stop and start bit are accepted.

Test Plan (bench uses CLKS_PER_BIT=8, TIMEOUT_BITS=32):
- Send 0x02,0x00,0x00,0x00,0x10 -> 5 wr_en with mosi 02,00,00,00,10; cmd=0x02; addr=0x00000010; pkt_done with 5th strobe; busy low afterwards.
- Send 0x01, addr 0xDEADBEEF, 512 bytes counting 0x00..0xFF twice -> 517 wr_en in order; addr=0xDEADBEEF; pkt_done only on the 517th strobe.
- Hold rx low for 3 clk then high (glitch) -> no wr_en, no frame_err; a following valid packet decodes correctly.
- Send 0x01 with stop bit forced 0 -> frame_err pulse, no wr_en, busy stays 0. Then send 0x02 + 4 bytes -> a normal packet.
- Send 0x55 -> cmd_err pulse, no wr_en. Send 0x01 + 2 addr bytes, then idle 300 clk -> timeout_err at 256 clk after the last byte_vld, busy cleared; the next 0x02 packet completes.
- Assert rst during F_DATA byte 100 -> all outputs 0 immediately, no pkt_done; a fresh cmd01 packet after release yields exactly 517 strobes.

Source files
------------

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver feeding a cmd01/cmd02 packet framer; accepted bytes leave as one-cycle wr_en strobes.
// wr_en follows the stop-bit mid-sample by 2 clk; errors and inter-byte timeouts abort the open packet.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PAYLOAD_LEN  = 512,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  mosi,
  output logic        wr_en,
  output logic [7:0]  cmd,
  output logic [31:0] addr,
  output logic        pkt_done,
  output logic        busy,
  output logic        frame_err,
  output logic        cmd_err,
  output logic        timeout_err
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_END    = TW'(TO_LIMIT - 1);
  localparam logic [9:0]    LAST_DATA = 10'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
  typedef enum logic [1:0] {F_CMD, F_ADDR, F_DATA} fr_state_t;

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t       rstate, rstate_n;
  logic [CW-1:0]   clk_cnt, clk_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            byte_vld, byte_vld_n;
  logic            frame_evt, frame_evt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate    <= R_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rstate    <= rstate_n;
      clk_cnt   <= clk_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      byte_vld  <= byte_vld_n;
      frame_evt <= frame_evt_n;
    end
  end

  always_comb begin
    rstate_n    = rstate;
    clk_cnt_n   = clk_cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    byte_vld_n  = 1'b0;
    frame_evt_n = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rstate_n  = R_START;
          clk_cnt_n = '0;
        end
      end
      R_START: begin
        if (clk_cnt == HALF_END) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          rstate_n  = rx_sync ? R_IDLE : R_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n = '0;
          shreg_n   = {rx_sync, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rstate_n = R_STOP;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n = '0;
          if (rx_sync) begin
            byte_vld_n = 1'b1;
            rstate_n   = R_IDLE;
          end else begin
            frame_evt_n = 1'b1;
            rstate_n    = R_WAIT;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
      R_WAIT: begin
        // A broken stop bit may leave the line low; resynchronise only once it idles.
        if (rx_sync) rstate_n = R_IDLE;
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  fr_state_t     fstate, fstate_n;
  logic [9:0]    byte_cnt, byte_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [7:0]    mosi_n, cmd_n;
  logic [31:0]   addr_n;
  logic          wr_en_n, pkt_done_n, busy_n, frame_err_n, cmd_err_n, timeout_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate      <= F_CMD;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      mosi        <= '0;
      wr_en       <= 1'b0;
      cmd         <= '0;
      addr        <= '0;
      pkt_done    <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      fstate      <= fstate_n;
      byte_cnt    <= byte_cnt_n;
      to_cnt      <= to_cnt_n;
      mosi        <= mosi_n;
      wr_en       <= wr_en_n;
      cmd         <= cmd_n;
      addr        <= addr_n;
      pkt_done    <= pkt_done_n;
      busy        <= busy_n;
      frame_err   <= frame_err_n;
      cmd_err     <= cmd_err_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    fstate_n      = fstate;
    byte_cnt_n    = byte_cnt;
    to_cnt_n      = to_cnt;
    mosi_n        = mosi;
    wr_en_n       = 1'b0;
    cmd_n         = cmd;
    addr_n        = addr;
    pkt_done_n    = 1'b0;
    busy_n        = busy;
    frame_err_n   = frame_evt;
    cmd_err_n     = 1'b0;
    timeout_err_n = 1'b0;
    case (fstate)
      F_CMD: begin
        if (byte_vld) begin
          if (shreg == 8'h01 || shreg == 8'h02) begin
            cmd_n      = shreg;
            addr_n     = '0;
            mosi_n     = shreg;
            wr_en_n    = 1'b1;
            busy_n     = 1'b1;
            byte_cnt_n = '0;
            to_cnt_n   = TW'(1);
            fstate_n   = F_ADDR;
          end else begin
            cmd_err_n = 1'b1;
          end
        end
      end
      F_ADDR, F_DATA: begin
        if (frame_evt) begin
          busy_n   = 1'b0;
          fstate_n = F_CMD;
        end else if (byte_vld) begin
          // Loading 1 makes timeout_err land exactly TO_LIMIT cycles after byte_vld.
          to_cnt_n   = TW'(1);
          mosi_n     = shreg;
          wr_en_n    = 1'b1;
          byte_cnt_n = byte_cnt + 10'd1;
          if (fstate == F_ADDR) begin
            addr_n = {addr[23:0], shreg};
            if (byte_cnt == 10'd3) begin
              byte_cnt_n = '0;
              if (cmd == 8'h02) begin
                pkt_done_n = 1'b1;
                busy_n     = 1'b0;
                fstate_n   = F_CMD;
              end else begin
                fstate_n = F_DATA;
              end
            end
          end else if (byte_cnt == LAST_DATA) begin
            pkt_done_n = 1'b1;
            busy_n     = 1'b0;
            fstate_n   = F_CMD;
          end
        end else if (to_cnt == TO_END) begin
          timeout_err_n = 1'b1;
          busy_n        = 1'b0;
          fstate_n      = F_CMD;
        end else begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end
      default: fstate_n = F_CMD;
    endcase
  end

endmodule
